// File: rtl/reset_req.sv
// reset_req: gathers reset requests from the push button, the watchdog and a
// software register write, and turns them into one stretched, level-high
// pulse for the board reset generator. The cause of the last request is held
// in a register that outlives the reset it provokes, so software can read it
// after restart.
//
// Only the IO side (ack, data_out, write acceptance) obeys rst. The request
// FSM, stretch counter, cause register and button debouncer run from their
// power-up values and ignore rst, because rst is itself produced by rst_req:
// clearing them would cut the pulse short.
//
// REQ_CYCLES must be at least 4 so the half-rate, double-synchronised
// generator input is guaranteed to see the pulse.
//
// IO handshake: a transfer happens on every clk edge where stb is high; ack
// follows one cycle later for exactly one cycle per stb cycle, together with
// the read word {27'b0, debounced, cause}. Writes return the pre-write cause.
// data_out is zero whenever ack is low.

module reset_req #(
    parameter int DEB_BITS   = 20,
    parameter int REQ_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    input  logic        wd_trig,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        rst_req
);

    localparam int CNT_W = $clog2(REQ_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Power-up initialised state; deliberately outside the reach of rst.
    state_t              r_state     = S_IDLE;
    logic [CNT_W-1:0]    r_cnt       = '0;
    logic [3:0]          r_cause     = 4'b1000;
    logic                r_btn_meta  = 1'b0;
    logic                r_btn_sync  = 1'b0;
    logic                r_deb       = 1'b0;
    logic                r_deb_d     = 1'b0;
    logic [DEB_BITS-1:0] r_deb_cnt   = '0;

    // IO-side registers, cleared by rst.
    logic                r_ack       = 1'b0;
    logic [31:0]         r_dout      = '0;

    state_t              w_state_nxt;
    logic                w_btn_evt;
    logic                w_wr;
    logic                w_sw_evt;
    logic                w_cause_clr;
    logic                w_any_req;
    logic                w_rst_req;
    logic                w_unused_data;

    // Only the two low write bits carry meaning.
    assign w_unused_data = ^data_in[31:2];

    // A write is accepted on any stb&we edge outside rst.
    assign w_wr        = stb & we & ~rst;
    assign w_sw_evt    = w_wr & data_in[0];
    assign w_cause_clr = w_wr & data_in[1] & ~data_in[0];
    assign w_btn_evt   = r_deb & ~r_deb_d;
    assign w_any_req   = w_btn_evt | wd_trig | w_sw_evt;

    // Button: two-flop synchroniser, then a stability counter that flips the
    // debounced level once the synced input has differed for 2^DEB_BITS edges.
    always_ff @(posedge clk) begin
        r_btn_meta <= btn_in;
        r_btn_sync <= r_btn_meta;
        r_deb_d    <= r_deb;
        if (r_btn_sync == r_deb) begin
            r_deb_cnt <= '0;
        end else if (&r_deb_cnt) begin
            r_deb     <= ~r_deb;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_BITS'(1);
        end
    end

    // Request FSM state register with its stretch counter and cause latch.
    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
        if (r_state == S_IDLE) begin
            if (w_any_req) begin
                r_cnt   <= CNT_W'(1);
                r_cause <= {1'b0, w_sw_evt, wd_trig, w_btn_evt};
            end else if (w_cause_clr) begin
                r_cause <= 4'b0000;
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next-state: any source starts a request; the pulse ends after REQ_CYCLES.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_REQ;
            S_REQ:   if (r_cnt == CNT_W'(REQ_CYCLES)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: the request is high for the whole REQ state.
    always_comb begin
        w_rst_req = 1'b0;
        if (r_state == S_REQ) w_rst_req = 1'b1;
    end

    assign rst_req = w_rst_req;

    // IO response: ack one cycle after each stb cycle, read word alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_ack  <= stb;
            r_dout <= stb ? {27'b0, r_deb, r_cause} : 32'h0;
        end
    end

    assign ack      = r_ack;
    assign data_out = r_dout;

endmodule

// File: tb/tb_reset_req.sv
// Directed bench for reset_req with a short debounce counter (DEB_BITS=4).
// Inputs are driven just after each falling edge and outputs are sampled on
// the falling edge, half a cycle away from the active rising edge.

module tb_reset_req;

    localparam int DEB = 4;
    localparam int REQ = 16;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        btn_in  = 1'b0;
    logic        wd_trig = 1'b0;
    logic        stb     = 1'b0;
    logic        we      = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        ack;
    logic        rst_req;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   g_highs = 0;
    int   g_rises = 0;
    logic g_prev  = 1'b0;
    logic [31:0] rd;

    reset_req #(
        .DEB_BITS   (DEB),
        .REQ_CYCLES (REQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .wd_trig  (wd_trig),
        .stb      (stb),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .rst_req  (rst_req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of sequence, expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next sample point and track rst_req pulse statistics.
    task automatic tick();
        @(negedge clk);
        if (rst_req === 1'b1) begin
            g_highs++;
            if (g_prev !== 1'b1) g_rises++;
        end
        g_prev = rst_req;
    endtask

    task automatic clr_stats();
        g_highs = 0;
        g_rises = 0;
        g_prev  = rst_req;
    endtask

    task automatic io_read(input string tag, input logic [31:0] exp);
        stb = 1'b1;
        we  = 1'b0;
        tick();
        chk({tag, "_ack"}, 32'(ack), 32'h1);
        chk({tag, "_data"}, data_out, exp);
        stb = 1'b0;
        tick();
        chk({tag, "_ack_low"}, 32'(ack), 32'h0);
        chk({tag, "_data_low"}, data_out, 32'h0);
    endtask

    // One-cycle write; returns the word presented with its ack.
    task automatic io_write(input logic [31:0] d, output logic [31:0] rdata);
        stb     = 1'b1;
        we      = 1'b1;
        data_in = d;
        tick();
        chk("wr_ack", 32'(ack), 32'h1);
        rdata   = data_out;
        stb     = 1'b0;
        we      = 1'b0;
        data_in = 32'h0;
    endtask

    task automatic drive_btn(input logic lvl, input int n);
        btn_in = lvl;
        repeat (n) tick();
    endtask

    initial begin
        // Power-up, then three cycles of rst.
        repeat (3) tick();
        chk("pwr_rst_req", 32'(rst_req), 32'h0);
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_rst_req", 32'(rst_req), 32'h0);
        end
        rst = 1'b0;
        tick();

        // stb held three cycles: three acks, each with the power-on cause.
        stb = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("held_ack_%0d", k), 32'(ack), 32'h1);
            chk($sformatf("held_data_%0d", k), data_out, 32'h8);
        end
        stb = 1'b0;
        tick();
        chk("held_ack_end", 32'(ack), 32'h0);
        io_read("pwr_cause", 32'h8);

        // Software request, with rst asserted across most of the pulse.
        clr_stats();
        io_write(32'h1, rd);
        chk("sw_wr_rdata", rd, 32'h8);
        chk("sw_pulse_1", 32'(rst_req), 32'h1);
        for (int k = 2; k <= 24; k++) begin
            if (k == 4)  rst = 1'b1;
            if (k == 22) rst = 1'b0;
            tick();
            chk($sformatf("sw_pulse_%0d", k), 32'(rst_req), 32'(k <= 16));
        end
        chk("sw_pulse_len", g_highs, 16);
        chk("sw_pulse_cnt", g_rises, 1);
        io_read("sw_cause", 32'h4);

        // Watchdog held: back-to-back pulses separated by one low cycle.
        clr_stats();
        wd_trig = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            if (k == 40) wd_trig = 1'b0;
            tick();
            chk($sformatf("wd_pulse_%0d", k), 32'(rst_req),
                32'((k <= 16) || (k >= 18 && k <= 33) || (k >= 35 && k <= 50)));
        end
        chk("wd_highs", g_highs, 48);
        chk("wd_rises", g_rises, 3);
        io_read("wd_cause", 32'h2);

        // Bouncing button, then held: exactly one request.
        clr_stats();
        drive_btn(1'b1, 5);
        drive_btn(1'b0, 3);
        drive_btn(1'b1, 10);
        drive_btn(1'b0, 7);
        drive_btn(1'b1, 12);
        drive_btn(1'b0, 2);
        drive_btn(1'b1, 100);
        chk("btn_highs", g_highs, 16);
        chk("btn_rises", g_rises, 1);
        io_read("btn_cause", 32'h11);

        // Release: no request on the falling debounced edge.
        clr_stats();
        drive_btn(1'b0, 40);
        chk("btn_rel_highs", g_highs, 0);
        io_read("btn_rel_cause", 32'h01);

        // Re-press: second request.
        clr_stats();
        drive_btn(1'b1, 50);
        chk("btn2_highs", g_highs, 16);
        chk("btn2_rises", g_rises, 1);
        io_read("btn2_cause", 32'h11);
        drive_btn(1'b0, 40);

        // Cause clear in IDLE.
        io_write(32'h2, rd);
        chk("clr_wr_rdata", rd, 32'h1);
        tick();
        io_read("clr_cause", 32'h0);

        // Clear and software writes during REQ are ignored.
        clr_stats();
        wd_trig = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 2) wd_trig = 1'b0;
            if (k == 4) begin stb = 1'b1; we = 1'b1; data_in = 32'h2; end
            if (k == 5) begin stb = 1'b0; we = 1'b0; data_in = 32'h0; end
            if (k == 7) begin stb = 1'b1; we = 1'b1; data_in = 32'h1; end
            if (k == 8) begin stb = 1'b0; we = 1'b0; data_in = 32'h0; end
            tick();
            chk($sformatf("req_ign_%0d", k), 32'(rst_req), 32'(k <= 16));
        end
        chk("req_ign_rises", g_rises, 1);
        io_read("req_ign_cause", 32'h2);

        // Write 3: software request wins over the clear bit.
        clr_stats();
        io_write(32'h3, rd);
        chk("w3_rdata", rd, 32'h2);
        repeat (20) tick();
        chk("w3_highs", g_highs, 16);
        chk("w3_rises", g_rises, 1);
        io_read("w3_cause", 32'h4);

        // Watchdog and software on the same edge: one pulse, both bits.
        clr_stats();
        wd_trig = 1'b1;
        stb     = 1'b1;
        we      = 1'b1;
        data_in = 32'h1;
        tick();
        wd_trig = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        data_in = 32'h0;
        repeat (24) tick();
        chk("both_highs", g_highs, 16);
        chk("both_rises", g_rises, 1);
        io_read("both_cause", 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
